// File: rtl/tt_tbuf_bus_rx_if.sv
// ---------------------------------------------------------------------------
// tt_tbuf_bus_rx_if
// Bundles the signals between the shared-bus receiver and its user.
//
// Signals (WIDTH = bus width):
//   bus_i      [WIDTH-1:0]  raw shared tristate bus, asynchronous to clk
//   own_oe                  local tristate driver enabled, synchronous
//   glitch_clr              clears the glitch counter
//   data_o     [WIDTH-1:0]  last settled bus value
//   data_vld                data_o is the current owner's settled value
//   chg_stb                 one-cycle pulse when data_o is (re)committed
//   rx_state   [1:0]        debug: 0 OWN, 1 GUARD, 2 SETTLE, 3 TRACK
//   glitch_cnt [7:0]        saturating glitch count
//
// Qualification: there is no ready.  data_o is meaningful only while
// data_vld is high.  chg_stb marks the single cycle in which a new
// commit becomes visible on data_o.  A consumer that misses it can
// still read data_o at any later point while data_vld stays high.
//
// master: the user of the receiver.  slave: the receiver itself.
// ---------------------------------------------------------------------------
interface tt_tbuf_bus_rx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] bus_i;
    logic             own_oe;
    logic             glitch_clr;
    logic [WIDTH-1:0] data_o;
    logic             data_vld;
    logic             chg_stb;
    logic [1:0]       rx_state;
    logic [7:0]       glitch_cnt;

    modport master (
        output bus_i, own_oe, glitch_clr,
        input  data_o, data_vld, chg_stb, rx_state, glitch_cnt
    );

    modport slave (
        input  bus_i, own_oe, glitch_clr,
        output data_o, data_vld, chg_stb, rx_state, glitch_cnt
    );
endinterface

// File: rtl/tt_tbuf_bus_rx.sv
// ---------------------------------------------------------------------------
// tt_tbuf_bus_rx
// Receiving end of a shared tristate bus.  The block performs these steps:
//   - Synchronizes bus_i through two flops, s1 and s2.
//   - Ignores the bus while the local driver owns it.
//   - Ignores the bus for GUARD_CYCLES edges after the local driver releases it.
//   - Accepts a value only after it has been seen on STABLE_CYCLES
//     consecutive edges.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   rx         tt_tbuf_bus_rx_if.slave.  It carries:
//              - inputs: bus_i, own_oe, glitch_clr
//              - outputs: data_o, data_vld, chg_stb, rx_state, glitch_cnt
//
// Optional feature: define TT_TBUF_RX_GLITCH_CNT_EN to build the glitch
// counter.
//   - With the macro defined, the counter increments, saturating, each time
//     a TRACK->SETTLE excursion re-commits the value already on data_o.
//   - Without the macro, glitch_cnt reads 0 and glitch_clr is ignored.
// ---------------------------------------------------------------------------
module tt_tbuf_bus_rx #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 4,
    parameter int GUARD_CYCLES  = 2
) (
    input  logic               clk,
    input  logic               rst,
    tt_tbuf_bus_rx_if.slave    rx
);
    typedef enum logic [1:0] {
        ST_OWN    = 2'd0,
        ST_GUARD  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_TRACK  = 2'd3
    } state_t;

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int GW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
    localparam logic [CW-1:0] S_MAX   = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_t           state, state_n;
    logic [WIDTH-1:0] s1, s2;
    logic [WIDTH-1:0] cand, cand_n;
    logic [WIDTH-1:0] data_q, data_n;
    logic [CW-1:0]    cnt, cnt_n, cnt_inc;
    logic [GW-1:0]    gcnt, gcnt_n;
    logic             vld_q, vld_n;
    logic             stb_q, stb_n;
    // Set while settling after a TRACK excursion; distinguishes a glitch
    // (same value re-committed) from a first commit after OWN/reset.
    logic             reentry, reentry_n;
    logic             commit;
    logic             glitch_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= '0;
            s2      <= '0;
            state   <= ST_SETTLE;
            cand    <= '0;
            cnt     <= '0;
            gcnt    <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            stb_q   <= 1'b0;
            reentry <= 1'b0;
        end else begin
            s1      <= rx.bus_i;
            s2      <= s1;
            state   <= state_n;
            cand    <= cand_n;
            cnt     <= cnt_n;
            gcnt    <= gcnt_n;
            data_q  <= data_n;
            vld_q   <= vld_n;
            stb_q   <= stb_n;
            reentry <= reentry_n;
        end
    end

    always_comb begin
        state_n    = state;
        cand_n     = cand;
        cnt_n      = cnt;
        cnt_inc    = '0;
        gcnt_n     = gcnt;
        data_n     = data_q;
        vld_n      = vld_q;
        stb_n      = 1'b0;
        reentry_n  = reentry;
        commit     = 1'b0;
        glitch_hit = 1'b0;

        if (rx.own_oe) begin
            // Local driver owns the bus: nothing from s2 can be trusted,
            // and this also pre-empts a commit due on the same edge.
            state_n   = ST_OWN;
            vld_n     = 1'b0;
            reentry_n = 1'b0;
            cnt_n     = '0;
        end else begin
            case (state)
                ST_OWN: begin
                    if (GUARD_CYCLES == 0) begin
                        state_n = ST_SETTLE;
                        cnt_n   = '0;
                    end else begin
                        state_n = ST_GUARD;
                        gcnt_n  = '0;
                    end
                end
                ST_GUARD: begin
                    if (int'(gcnt) + 1 >= GUARD_CYCLES) begin
                        state_n = ST_SETTLE;
                        cnt_n   = '0;
                    end else begin
                        gcnt_n = gcnt + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (s2 == cand) begin
                        cnt_inc = (cnt == S_MAX) ? cnt : cnt + 1'b1;
                    end else begin
                        cnt_inc = CNT_ONE;
                    end
                    cand_n = s2;
                    cnt_n  = cnt_inc;
                    commit = (cnt_inc == S_MAX);
                end
                ST_TRACK: begin
                    // The differing sample counts as the first of the new run.
                    if (s2 != data_q) begin
                        cand_n    = s2;
                        cnt_n     = CNT_ONE;
                        reentry_n = 1'b1;
                        state_n   = ST_SETTLE;
                        commit    = (CNT_ONE == S_MAX);
                    end
                end
                default: state_n = ST_SETTLE;
            endcase

            if (commit) begin
                glitch_hit = reentry && (s2 == data_q);
                stb_n      = !glitch_hit;
                data_n     = s2;
                vld_n      = 1'b1;
                reentry_n  = 1'b0;
                state_n    = ST_TRACK;
            end
        end
    end

    assign rx.data_o   = data_q;
    assign rx.data_vld = vld_q;
    assign rx.chg_stb  = stb_q;
    assign rx.rx_state = state;

`ifdef TT_TBUF_RX_GLITCH_CNT_EN
    logic [7:0] glitch_q;

    // Clear wins over a coincident glitch.
    always_ff @(posedge clk) begin
        if (rst || rx.glitch_clr) begin
            glitch_q <= 8'h00;
        end else if (glitch_hit && (glitch_q != 8'hFF)) begin
            glitch_q <= glitch_q + 8'h01;
        end
    end

    assign rx.glitch_cnt = glitch_q;
`else
    logic unused_glitch;
    assign unused_glitch = &{1'b0, glitch_hit, rx.glitch_clr};
    assign rx.glitch_cnt = 8'h00;
`endif

endmodule

// File: doc/tt_tbuf_bus_rx.md
Name: tt_tbuf_bus_rx

Overview:
- Reader side of a shared tristate bus. The bus is driven by tristate buffers in several designs; this block is the receiving end.
- Synchronizes the bus, rejects samples taken while the local tristate driver owns the bus or is still turning around, and debounces the value.
- Presents a settled value with a valid level and a change strobe.
- Sits next to the local tristate driver on the bus wiring in the mux/control path.

Parameters:
- WIDTH, 8, bus width in bits.
- STABLE_CYCLES, 4, number of consecutive equal synchronized samples required to accept a value; legal range >= 1.
- GUARD_CYCLES, 2, number of cycles ignored after the local driver releases the bus; legal range >= 0.

Ports:
- clk  input  1  block clock.
- rst  input  1  synchronous reset, active-high.
- bus_i  input  WIDTH  raw shared tristate bus; asynchronous to clk.
- own_oe  input  1  high while the local tristate driver is enabled (drives the bus); synchronous to clk.
- data_o  output  WIDTH  last settled bus value.
- data_vld  output  1  data_o reflects the current bus owner's settled value.
- chg_stb  output  1  one-cycle pulse when data_o is (re)committed.
- rx_state  output  2  current FSM state, for debug: 0 OWN, 1 GUARD, 2 SETTLE, 3 TRACK.
- glitch_cnt  output  8  saturating glitch count (see Optional Feature).
- glitch_clr  input  1  clears glitch_cnt.

Behaviour:
- Synchronizer:
  - Two flops, s1 and s2, on bus_i. Both reset to 0.
  - All decisions use s2 only.
- Reset:
  - State goes to SETTLE with the stability counter at 0.
  - data_o=0, data_vld=0, chg_stb=0, glitch_cnt=0.
  - Reset asserted mid-operation aborts any state immediately on the next edge.
- own_oe priority:
  - own_oe=1 on any edge forces state to OWN and data_vld to 0. data_o holds its value.
  - own_oe has priority over every other transition.
- OWN: own_oe=0 -> GUARD, with the guard counter at 0. If GUARD_CYCLES=0, go to SETTLE directly.
- GUARD:
  - Ignores s2 and counts edges.
  - After GUARD_CYCLES edges in GUARD -> SETTLE, with the stability counter at 0.
- SETTLE:
  - Tracks candidate=s2 and a stability counter (cnt).
  - If s2 equals the previous candidate, cnt increments; otherwise cnt=1 and candidate=s2.
  - When cnt reaches STABLE_CYCLES: data_o<=candidate, data_vld<=1, chg_stb pulses for one cycle, state -> TRACK.
  - Exception: re-entry from TRACK that resolves to an unchanged value. In that case there is no chg_stb, and a glitch is counted.
  - After OWN/GUARD or reset, the first commit always pulses chg_stb, even if the value equals the old data_o.
- TRACK:
  - s2 == data_o: stay in TRACK.
  - s2 != data_o: -> SETTLE with candidate=s2 and cnt=1. data_vld stays 1 and data_o holds the old value until a new commit.
- Latency:
  - A bus step held steady before edge k (the first edge that loads s1) commits on edge k+1+STABLE_CYCLES.
  - chg_stb is high in the cycle following that edge.
- Counter widths: sized with $clog2(max+1). There is no wrap: the stability counter stops at STABLE_CYCLES and the guard counter stops at GUARD_CYCLES.
- Simultaneous events:
  - own_oe rising in the same edge a commit would occur: OWN wins, with no commit and no chg_stb.
  - glitch_clr coinciding with a glitch: the clear wins, and the count is 0.

Optional Feature:
- Macro: TT_TBUF_RX_GLITCH_CNT_EN.
- Defined:
  - glitch_cnt increments, saturating at 255, whenever a TRACK->SETTLE excursion re-commits the same value as data_o.
  - glitch_clr synchronously zeroes the count.
- Not defined:
  - glitch_cnt is tied to 8'h00 and glitch_clr is ignored.
  - No counter flops are built.
- The port list is identical either way.

Test Plan:
- Settle after reset: WIDTH=8, STABLE_CYCLES=4, GUARD_CYCLES=2. Release rst with bus_i=8'hA5 held -> data_o=8'hA5, data_vld=1, and one chg_stb pulse; rx_state ends at 3.
- Latency: in TRACK, step bus_i 8'hA5->8'h3C before edge k -> data_o=8'h3C at edge k+5; chg_stb high for exactly one cycle; data_o=8'hA5 and data_vld=1 until then.
- Glitch rejection: in TRACK with data_o=8'h3C, pulse bus_i to 8'hFF for 2 cycles, then restore -> data_o stays 8'h3C and there is no chg_stb. glitch_cnt=1 with the macro defined, 0 without.
- Turnaround: assert own_oe for 5 cycles, then deassert with bus_i=8'h00 -> data_vld=0 from the edge after own_oe rises. Bus ignored for 2 guard edges. Commit 8'h00 at guard end +4 edges, with chg_stb even if the value is unchanged.
- Priority: raise own_oe on the edge where a SETTLE commit is due -> state OWN, no chg_stb, data_o unchanged.
- Saturation/clear (macro defined): generate 300 glitches -> glitch_cnt=255. Assert glitch_clr coincident with a glitch -> glitch_cnt=0.
